alu_issue: RTL
==============

# alu_issue

Decode/issue stage that feeds the datapath ALU. Accepts one MIPS instruction word plus its register-file operands per handshake, decodes opcode/funct into the ALU's 4-bit `alu_control` encoding, selects and extends operands, and holds the result in an ID/EX pipeline register with valid/ready flow control and flush.

## Interface
- `DATA_W`, 32, operand width; only 32 is supported.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `flush` input 1: discards all held entries.
- `in_valid` input 1: `instr`/`rs_data`/`rt_data` valid.
- `in_ready` output 1: stage accepts input this cycle.
- `instr` input 32: instruction word.
- `rs_data` input DATA_W: register value for `instr[25:21]`.
- `rt_data` input DATA_W: register value for `instr[20:16]`.
- `out_valid` output 1: issue entry valid.
- `out_ready` input 1: ALU stage consumes the entry.
- `out_a` output DATA_W: ALU input 1.
- `out_b` output DATA_W: ALU input 2.
- `out_alu_control` output 4: ALU function select.
- `out_dest` output 5: destination register number.
- `out_reg_write` output 1: writeback enable.
- `out_illegal` output 1: unsupported encoding.

## Operation
- Accept when `in_valid && in_ready`. Issue when `out_valid && out_ready`.
- R-type (opcode 0x00), keyed on funct. Destination is rd and `reg_write` is 1.
  - Immediate shifts: sll 0x00→0001, srl 0x02→0010, sra 0x03→0011. `a`=rt_data, `b`=zero-extended shamt.
  - Variable shifts: sllv 0x04→0100, srlv 0x06→0101, srav 0x07→0110. `a`=rs_data, `b`=rt_data.
  - ALU ops, `a`=rs_data, `b`=rt_data:
    - add/addu 0x20/0x21→1000
    - sub/subu 0x22/0x23→1001
    - and 0x24→1010, or 0x25→1011, xor 0x26→1100, nor 0x27→1101
    - slt 0x2A→1110, sltu 0x2B→1111
- I-type, `a`=rs_data, destination rt, `reg_write`=1:
  - Sign-extended immediate: addi/addiu 0x08/0x09→1000, slti 0x0A→1110, sltiu 0x0B→1111, lw 0x23→1000.
  - Zero-extended immediate: andi 0x0C→1010, ori 0x0D→1011, xori 0x0E→1100.
  - lui 0x0F→0111, `b`=zero-extended imm. The ALU performs the shift by 16.
- sw 0x2B→1000, sign-extended imm, `reg_write`=0.
- beq 0x04 and bne 0x05→1001, `a`=rs_data, `b`=rt_data, `reg_write`=0.
- Any other opcode/funct sets `illegal`=1 and `reg_write`=0, with control 1000, `a`=rs_data, `b`=rt_data, `dest`=0.
- `dest`=0 forces `reg_write`=0. $zero is never written.
- Flow control: `in_ready = !out_valid || out_ready`. Capture and issue can occur in the same cycle.
- `flush`:
  - Next edge: `out_valid`=0; any skid entry is dropped.
  - Input presented during the flush cycle is not captured. `in_ready`=0 while `flush`=1.
- Output fields hold stable while `out_valid && !out_ready`.

## Timing
- Latency is 1 cycle: accepted at edge N, `out_valid` asserts after edge N.
- Throughput is 1 instruction/cycle with `out_ready` held high.
- Reset (asynchronous, immediate) drives every output register to 0: `out_valid`, `out_a`, `out_b`, `out_alu_control`, `out_dest`, `out_reg_write`, `out_illegal`. Skid state is also cleared.
- `in_ready` is 1 while in reset and after reset, except during `flush`.
- Reset mid-stream: the held entry is lost and no partial issue occurs.
- Flush and `out_ready` in the same cycle: flush wins, but the ALU has already consumed the entry presented in that cycle.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Adds a one-entry skid buffer.
  - `in_ready = !skid_full && !flush`, driven from registers only; there is no combinational path from `out_ready`.
  - An input accepted while the output is stalled goes to the skid entry and moves to the output in order when it frees.
  - Latency is unchanged (1 cycle) when the output is empty.
- Undefined:
  - Single register.
  - `in_ready = (!out_valid || out_ready) && !flush`.

## Test plan
- add: `instr`=0x012A4020 (add $8,$9,$10), rs=5, rt=7, `out_ready`=1 → next cycle `out_valid`=1, ctl=1000, a=5, b=7, dest=8, `reg_write`=1.
- Shift and lui:
  - sra $2,$3,4 with rt_data=0x80000000 → ctl=0011, a=0x80000000, b=4, dest=2.
  - lui $4,0x1234 → ctl=0111, b=0x00001234, dest=4.
- Extension:
  - addi imm 0xFFFF → b=0xFFFFFFFF.
  - andi imm 0xFFFF → b=0x0000FFFF, ctl=1010.
  - sw → `reg_write`=0.
- Illegal: funct 0x18 (mult) → `illegal`=1, `reg_write`=0, ctl=1000. Writing to $0 (add $0,$1,$2) → `reg_write`=0.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 and distinct instructions.
  - Output fields remain stable.
  - No instruction is lost or duplicated; order is preserved.
  - With `ALU_ISSUE_SKID_EN`, exactly one extra instruction is accepted.
- Flush/reset:
  - Assert `flush` with `out_valid`=1 and `in_valid`=1 → next cycle `out_valid`=0 and the new input is not issued.
  - Pulse `rst_n` low mid-stream → all outputs become 0 immediately.

Source files
------------

// File: rtl/alu_issue.sv
// alu_issue: decode/issue stage in front of the datapath ALU.
// Decodes one MIPS instruction per handshake into the 4-bit ALU control code,
// selects and extends the operands, and holds the result in an ID/EX register
// with valid/ready flow control and flush.
// Optional build macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer so that
// in_ready is driven from registers only.
module alu_issue #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_alu_control,
    output logic [4:0]        out_dest,
    output logic              out_reg_write,
    output logic              out_illegal
);

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        ctl;
        logic [4:0]        dest;
        logic              wr;
        logic              ill;
    } entry_t;

    logic [5:0]        opcode;
    logic [5:0]        funct;
    logic [4:0]        rt_idx;
    logic [4:0]        rd_idx;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [DATA_W-1:0] imm_sx;
    logic [DATA_W-1:0] imm_zx;
    logic [DATA_W-1:0] shamt_zx;
    logic              dec_wr;
    entry_t            dec;

    assign opcode   = instr[31:26];
    assign rt_idx   = instr[20:16];
    assign rd_idx   = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm      = instr[15:0];
    assign imm_sx   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx   = {{(DATA_W-16){1'b0}}, imm};
    assign shamt_zx = {{(DATA_W-5){1'b0}}, shamt};

    // Decode opcode/funct into ALU control, operand selection and destination.
    // Unsupported encodings fall back to an add of rs/rt that never writes back.
    always_comb begin
        dec.a   = rs_data;
        dec.b   = rt_data;
        dec.ctl = 4'b1000;
        dec.dest = 5'd0;
        dec.ill = 1'b0;
        dec_wr  = 1'b0;
        unique case (opcode)
            6'h00: begin
                dec.dest = rd_idx;
                dec_wr   = 1'b1;
                unique case (funct)
                    6'h00: begin dec.ctl = 4'b0001; dec.a = rt_data; dec.b = shamt_zx; end
                    6'h02: begin dec.ctl = 4'b0010; dec.a = rt_data; dec.b = shamt_zx; end
                    6'h03: begin dec.ctl = 4'b0011; dec.a = rt_data; dec.b = shamt_zx; end
                    6'h04: dec.ctl = 4'b0100;
                    6'h06: dec.ctl = 4'b0101;
                    6'h07: dec.ctl = 4'b0110;
                    6'h20, 6'h21: dec.ctl = 4'b1000;
                    6'h22, 6'h23: dec.ctl = 4'b1001;
                    6'h24: dec.ctl = 4'b1010;
                    6'h25: dec.ctl = 4'b1011;
                    6'h26: dec.ctl = 4'b1100;
                    6'h27: dec.ctl = 4'b1101;
                    6'h2A: dec.ctl = 4'b1110;
                    6'h2B: dec.ctl = 4'b1111;
                    default: begin
                        dec.ill  = 1'b1;
                        dec.dest = 5'd0;
                        dec_wr   = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h23: begin
                dec.ctl = 4'b1000; dec.b = imm_sx; dec.dest = rt_idx; dec_wr = 1'b1;
            end
            6'h0A: begin dec.ctl = 4'b1110; dec.b = imm_sx; dec.dest = rt_idx; dec_wr = 1'b1; end
            6'h0B: begin dec.ctl = 4'b1111; dec.b = imm_sx; dec.dest = rt_idx; dec_wr = 1'b1; end
            6'h0C: begin dec.ctl = 4'b1010; dec.b = imm_zx; dec.dest = rt_idx; dec_wr = 1'b1; end
            6'h0D: begin dec.ctl = 4'b1011; dec.b = imm_zx; dec.dest = rt_idx; dec_wr = 1'b1; end
            6'h0E: begin dec.ctl = 4'b1100; dec.b = imm_zx; dec.dest = rt_idx; dec_wr = 1'b1; end
            // The ALU itself shifts the immediate into the upper half.
            6'h0F: begin dec.ctl = 4'b0111; dec.b = imm_zx; dec.dest = rt_idx; dec_wr = 1'b1; end
            // Store and branches compute an address/compare only; no register result.
            6'h2B: begin dec.ctl = 4'b1000; dec.b = imm_sx; end
            6'h04, 6'h05: dec.ctl = 4'b1001;
            default: dec.ill = 1'b1;
        endcase
    end

    // $zero is never written, whatever the encoding asked for.
    always_comb begin
        dec.wr = dec_wr && (dec.dest != 5'd0);
    end

    entry_t out_q, out_d;
    logic   out_valid_q, out_valid_d;
    logic   accept;
    logic   out_free;

    assign out_free = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
    entry_t skid_q, skid_d;
    logic   skid_full_q, skid_full_d;

    // Ready depends only on registered state and flush, never on out_ready.
    assign in_ready = !skid_full_q && !flush;

    // Output register refills from the skid entry first so order is kept;
    // a capture while stalled parks in the skid entry.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (flush) begin
            out_valid_d = 1'b0;
            skid_full_d = 1'b0;
        end else if (out_free) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = dec;
            skid_full_d = 1'b1;
        end
    end

    // Skid entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else begin
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
        end
    end
`else
    assign in_ready = out_free && !flush;

    // Single register: load on capture, drop on issue, hold while stalled.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // ID/EX output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid       = out_valid_q;
    assign out_a           = out_q.a;
    assign out_b           = out_q.b;
    assign out_alu_control = out_q.ctl;
    assign out_dest        = out_q.dest;
    assign out_reg_write   = out_q.wr;
    assign out_illegal     = out_q.ill;

endmodule
